// File: rtl/divisor_4_bits_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package divisor_4_bits_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divisor_4_bits_if.sv
// Start/done handshake bundle between a requester (master) and the divider (slave).
interface divisor_4_bits_if
  import divisor_4_bits_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] dividendo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quociente;
  logic [WIDTH-1:0] resto;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, dividendo, divisor,
    input  quociente, resto, busy, done, div_zero
  );

  modport slave (
    input  start, dividendo, divisor,
    output quociente, resto, busy, done, div_zero
  );

endinterface

// File: rtl/divisor_4_bits_subtrator.sv
// Ripple-borrow subtractor (a - b) built from full_subtractor cells, mirroring the ripple adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

module subtrator_4_bits #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  logic [N:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    full_subtractor u_cell (
      .a         (a[i]),
      .b         (b[i]),
      .borrow_in (borrow[i]),
      .diff      (diff[i]),
      .borrow_out(borrow[i+1])
    );
  end

  assign borrow_out = borrow[N];

endmodule

// File: rtl/divisor_4_bits.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional zero-divisor short-cut enabled by defining DIV_ZERO_CHECK_EN.
module divisor_4_bits
  import divisor_4_bits_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  divisor_4_bits_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quociente_r;
  logic [WIDTH-1:0] resto_r;
  logic             done_r;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             take;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  subtrator_4_bits #(.N(WIDTH + 1)) u_sub (
    .a         (r_shift),
    .b         ({1'b0, d_reg}),
    .diff      (trial),
    .borrow_out(borrow)
  );

  // A set top bit in R means the shifted value overflowed the subtractor, so it certainly fits.
  assign take   = ~borrow | r_reg[WIDTH];
  assign r_next = take ? trial : r_shift;
  assign q_next = {q_reg[WIDTH-2:0], take};

`ifdef DIV_ZERO_CHECK_EN
  logic div_zero_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quociente_r <= '0;
      resto_r     <= '0;
      done_r      <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      div_zero_r  <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            d_reg <= bus.divisor;
            q_reg <= bus.dividendo;
            r_reg <= '0;
            cnt   <= '0;
            state <= CALC;
`ifdef DIV_ZERO_CHECK_EN
            div_zero_r <= 1'b0;
            if (bus.divisor == '0) begin
              quociente_r <= '1;
              resto_r     <= bus.dividendo;
              div_zero_r  <= 1'b1;
              done_r      <= 1'b1;
              state       <= DONE;
            end
`endif
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            quociente_r <= q_next;
            resto_r     <= r_next[WIDTH-1:0];
            done_r      <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quociente = quociente_r;
  assign bus.resto     = resto_r;
  assign bus.done      = done_r;
  assign bus.busy      = (state != IDLE);
`ifdef DIV_ZERO_CHECK_EN
  assign bus.div_zero  = div_zero_r;
`else
  assign bus.div_zero  = 1'b0;
`endif

endmodule
